// File: rtl/conv_window_tracker_pkg.sv
// Shared layer definitions for the convolution/pooling front end:
// LeNet layer geometry, a counter-width helper and the tracker FSM encoding.
package conv_window_tracker_pkg;

  // LeNet C1: 32x32 input, 5x5 kernel
  localparam int C1_IMG_W = 32;
  localparam int C1_IMG_H = 32;
  localparam int C1_K     = 5;

  // LeNet C3: 14x14 input, 5x5 kernel
  localparam int C3_IMG_W = 14;
  localparam int C3_IMG_H = 14;
  localparam int C3_K     = 5;

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int width_of(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/conv_window_tracker_raster_counter.sv
// Raster-order column/row counter with enable, synchronous clear and
// end-of-frame flag. Shared by the convolution and pooling stages.
module raster_counter
  import conv_window_tracker_pkg::*;
#(
  parameter int W  = 32,
  parameter int H  = 32,
  parameter int CW = width_of(W),
  parameter int RW = width_of(H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          row_end,
  output logic          frame_end
);

  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  // Flags describe the pixel position currently held, i.e. the one about to be accepted
  always_comb begin
    row_end   = (col == COL_LAST);
    frame_end = (col == COL_LAST) && (row == ROW_LAST);
  end

  // Advance one pixel per enabled cycle, wrapping column into the next row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (row_end) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_window_tracker.sv
// Raster-position tracker for a stride-1 KxK convolution stage. Emits a
// registered window strobe with output-map coordinates for each accepted
// pixel that completes a full window, plus frame start/done sequencing.
//
// state | meaning
// IDLE  | waiting for start; pixels ignored, counters held at zero
// RUN   | counting accepted pixels and emitting window strobes
// DONE  | frame_done/busy=0 visible; start ignored; back to IDLE next cycle
module conv_window_tracker
  import conv_window_tracker_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K     = 5,
  parameter int OCW   = width_of(IMG_W - K + 1),
  parameter int ORW   = width_of(IMG_H - K + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           pix_valid,
  output logic           busy,
  output logic           win_valid,
  output logic [OCW-1:0] out_col,
  output logic [ORW-1:0] out_row,
  output logic           last_win,
  output logic           frame_done
);

  localparam int CW = width_of(IMG_W);
  localparam int RW = width_of(IMG_H);
  localparam logic [CW-1:0] COL_OFS = CW'(K - 1);
  localparam logic [RW-1:0] ROW_OFS = RW'(K - 1);

  state_t        state;
  logic          final_pend;
  logic          accept;
  logic          counter_clear;
  logic          in_window;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          row_end;
  logic          frame_end;

  // Pixel acceptance and window test for the pixel presented this cycle
  always_comb begin
    accept        = (state == ST_RUN) && pix_valid && !final_pend;
    counter_clear = (state == ST_IDLE);
    in_window     = (col >= COL_OFS) && (row >= ROW_OFS);
  end

  raster_counter #(
    .W  (IMG_W),
    .H  (IMG_H),
    .CW (CW),
    .RW (RW)
  ) u_raster (
    .clk       (clk),
    .reset     (reset),
    .clear     (counter_clear),
    .en        (accept),
    .col       (col),
    .row       (row),
    .row_end   (row_end),
    .frame_end (frame_end)
  );

  // Frame sequencing with registered strobes; final_pend spaces frame_done
  // one cycle behind the last window strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      final_pend <= 1'b0;
      busy       <= 1'b0;
      win_valid  <= 1'b0;
      last_win   <= 1'b0;
      out_col    <= '0;
      out_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      last_win   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          final_pend <= 1'b0;
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (final_pend) begin
            state      <= ST_DONE;
            final_pend <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else if (accept) begin
            if (in_window) begin
              win_valid <= 1'b1;
              last_win  <= frame_end;
              out_col   <= OCW'(col - COL_OFS);
              out_row   <= ORW'(row - ROW_OFS);
            end
            if (frame_end) begin
              final_pend <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_tracker.sv
// Directed bench for conv_window_tracker at 32x32, K=5.
module tb_conv_window_tracker;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int K    = 5;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - K + 1) * (H - K + 1);

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pix_valid;
  logic       busy;
  logic       win_valid;
  logic [4:0] out_col;
  logic [4:0] out_row;
  logic       last_win;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;

  int         seq_err;
  int         bad_idx;
  int         pulses;
  int         first_idx;
  logic [4:0] held_col;
  logic [4:0] held_row;
  logic       fin_wv;
  logic       fin_lw;
  logic [4:0] fin_col;
  logic [4:0] fin_row;

  conv_window_tracker #(
    .IMG_W (W),
    .IMG_H (H),
    .K     (K)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pix_valid  (pix_valid),
    .busy       (busy),
    .win_valid  (win_valid),
    .out_col    (out_col),
    .out_row    (out_row),
    .last_win   (last_win),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input string tag);
    start     = 1'b1;
    pix_valid = 1'b0;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy_after_start: busy=%b expected 1", tag, busy);
    end
  endtask

  // Feed npix pixels, comparing every cycle against the raster model
  task automatic run_pixels(input bit gaps, input bit noise, input int npix);
    int  p;
    int  r;
    int  c;
    bit  phase;
    bit  ew;
    bit  el;
    p         = 0;
    phase     = 1'b0;
    seq_err   = 0;
    bad_idx   = -1;
    pulses    = 0;
    first_idx = -1;
    while (p < npix) begin
      if (gaps && phase) begin
        pix_valid = 1'b0;
        start     = noise;
        tick();
        if (win_valid !== 1'b0 || last_win !== 1'b0 || out_col !== held_col ||
            out_row !== held_row || busy !== 1'b1) begin
          seq_err++;
          if (bad_idx < 0) bad_idx = p;
        end
      end else begin
        pix_valid = 1'b1;
        start     = noise && (p % 3 == 0);
        tick();
        r  = p / W;
        c  = p % W;
        ew = (c >= K - 1) && (r >= K - 1);
        el = ew && (r == H - 1) && (c == W - 1);
        if (ew) begin
          held_col = 5'(c - (K - 1));
          held_row = 5'(r - (K - 1));
        end
        if (win_valid !== ew || last_win !== el || out_col !== held_col ||
            out_row !== held_row || busy !== 1'b1) begin
          seq_err++;
          if (bad_idx < 0) bad_idx = p;
        end
        if (win_valid === 1'b1) begin
          pulses++;
          if (first_idx < 0) first_idx = p;
        end
        if (p == npix - 1) begin
          fin_wv  = win_valid;
          fin_lw  = last_win;
          fin_col = out_col;
          fin_row = out_row;
        end
        p++;
      end
      phase = ~phase;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    checks++;
    if (seq_err != 0) begin
      failures++;
      $display("FAIL %s_sequence: %0d bad cycles (first at pixel %0d) expected 0",
               tag, seq_err, bad_idx);
    end
    checks++;
    if (pulses != NWIN) begin
      failures++;
      $display("FAIL %s_pulse_count: got %0d expected %0d", tag, pulses, NWIN);
    end
    checks++;
    if (first_idx != 132) begin
      failures++;
      $display("FAIL %s_first_window: pixel %0d expected 132", tag, first_idx);
    end
    checks++;
    if (fin_wv !== 1'b1 || fin_lw !== 1'b1 || fin_col !== 5'd27 || fin_row !== 5'd27) begin
      failures++;
      $display("FAIL %s_last_window: wv=%b last=%b col=%0d row=%0d expected 1 1 27 27",
               tag, fin_wv, fin_lw, fin_col, fin_row);
    end
  endtask

  // Cycle after the last strobe, then the frame_done cycle, then idle
  task automatic finish_frame(input string tag, input bit start_noise);
    pix_valid = 1'b0;
    start     = start_noise;
    tick();
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || win_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_frame_done: done=%b busy=%b wv=%b expected 1 0 0",
               tag, frame_done, busy, win_valid);
    end
    tick();
    start = 1'b0;
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_after_done: done=%b busy=%b expected 0 0", tag, frame_done, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_busy: busy=%b expected 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    int err;
    reset     = 1'b1;
    start     = 1'b0;
    pix_valid = 1'b0;
    held_col  = '0;
    held_row  = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || win_valid !== 1'b0 || last_win !== 1'b0 || frame_done !== 1'b0 ||
        out_col !== 5'd0 || out_row !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b wv=%b last=%b done=%b col=%0d row=%0d expected all 0",
               busy, win_valid, last_win, frame_done, out_col, out_row);
    end
    tick();
    tick();
    reset = 1'b0;
    err   = 0;
    pix_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (win_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) err++;
    end
    pix_valid = 1'b0;
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL idle_ignores_pixels: %0d active cycles expected 0", err);
    end
  endtask

  task automatic test_full_frame();
    start_frame("full");
    run_pixels(1'b0, 1'b0, NPIX);
    check_frame("full");
    finish_frame("full", 1'b0);
  endtask

  task automatic test_gapped_frame();
    start_frame("gapped");
    run_pixels(1'b1, 1'b0, NPIX);
    check_frame("gapped");
    finish_frame("gapped", 1'b0);
  endtask

  task automatic test_row_wrap();
    start_frame("wrap");
    pix_valid = 1'b1;
    for (int p = 0; p <= 164; p++) begin
      tick();
      if (p == 159) begin
        checks++;
        if (win_valid !== 1'b1 || out_col !== 5'd27 || out_row !== 5'd0) begin
          failures++;
          $display("FAIL wrap_row_end: wv=%b col=%0d row=%0d expected 1 27 0",
                   win_valid, out_col, out_row);
        end
      end
      if (p == 160) begin
        checks++;
        if (win_valid !== 1'b0) begin
          failures++;
          $display("FAIL wrap_row_start: wv=%b expected 0", win_valid);
        end
      end
      if (p == 164) begin
        checks++;
        if (win_valid !== 1'b1 || out_col !== 5'd0 || out_row !== 5'd1) begin
          failures++;
          $display("FAIL wrap_next_row: wv=%b col=%0d row=%0d expected 1 0 1",
                   win_valid, out_col, out_row);
        end
      end
    end
    pix_valid = 1'b0;
    reset     = 1'b1;
    tick();
    reset    = 1'b0;
    held_col = '0;
    held_row = '0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    start_frame("midrst");
    run_pixels(1'b0, 1'b0, 500);
    pix_valid = 1'b1;
    reset     = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || win_valid !== 1'b0 || last_win !== 1'b0 || frame_done !== 1'b0 ||
        out_col !== 5'd0 || out_row !== 5'd0) begin
      failures++;
      $display("FAIL midrst_outputs: busy=%b wv=%b last=%b done=%b col=%0d row=%0d expected all 0",
               busy, win_valid, last_win, frame_done, out_col, out_row);
    end
    tick();
    reset     = 1'b0;
    pix_valid = 1'b0;
    held_col  = '0;
    held_row  = '0;
    tick();
    start_frame("postrst");
    run_pixels(1'b0, 1'b0, NPIX);
    check_frame("postrst");
    finish_frame("postrst", 1'b0);
  endtask

  task automatic test_back_to_back();
    start_frame("b2b_a");
    run_pixels(1'b0, 1'b1, NPIX);
    check_frame("b2b_a");
    finish_frame("b2b_a", 1'b1);
    start_frame("b2b_b");
    run_pixels(1'b0, 1'b0, NPIX);
    check_frame("b2b_b");
    finish_frame("b2b_b", 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gapped_frame();
    test_row_wrap();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
